// File: rtl/mem_responder.sv
// Data-memory responder: valid/ready load/store port into a word array with LATENCY wait states.
// Optional MEM_RESP_ALIGN_CHECK_EN: misaligned requests respond with resp_err and never write.
module mem_responder #(
  parameter int DEPTH_LOG2 = 14,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    bad_q, bad_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [31:0]             mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0]   req_idx_s;
  logic                    req_bad_s;
  logic                    acc_en_s;
  logic                    acc_we_s;
  logic [DEPTH_LOG2-1:0]   acc_idx_s;
  logic [31:0]             acc_wdata_s;
  logic                    acc_bad_s;
  logic                    mem_wr_s;
  logic                    unused_s;

  // Upper address bits fall away so the array aliases modulo its byte size.
  assign req_idx_s = req_addr[DEPTH_LOG2+1:2];
  assign unused_s  = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign req_bad_s = (req_addr[1:0] != 2'b00);
`else
  assign req_bad_s = 1'b0;
`endif

  // Next-state, request capture and access-edge decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    acc_en_s    = 1'b0;
    acc_we_s    = we_q;
    acc_idx_s   = idx_q;
    acc_wdata_s = wdata_q;
    acc_bad_s   = bad_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_idx_s;
          wdata_d = req_wdata;
          bad_d   = req_bad_s;
          if (LATENCY == 0) begin
            // Zero wait states: the accept edge is also the access edge.
            acc_en_s    = 1'b1;
            acc_we_s    = req_we;
            acc_idx_s   = req_idx_s;
            acc_wdata_s = req_wdata;
            acc_bad_s   = req_bad_s;
            state_d     = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_en_s = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc_en_s) begin
      err_d = acc_bad_s;
      if (acc_bad_s || acc_we_s) begin
        rdata_d = 32'h0000_0000;
      end else begin
        rdata_d = mem_q[acc_idx_s];
      end
    end else begin
      err_d = err_q;
    end
  end

  assign mem_wr_s = acc_en_s & acc_we_s & ~acc_bad_s;

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0000_0000;
      bad_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Data array: contents survive reset, but a reset edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_wr_s && rst) begin
      mem_q[acc_idx_s] <= acc_wdata_s;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
